// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: widths, FSM encodings, constants.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory lookup plus valid/ready delivery to decode.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_addr, if_valid, if_pc, if_instr,
    input  imem_instr, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_pc, if_instr,
    output imem_instr, if_ready
  );

endinterface

// File: rtl/fetch_sequencer_fifo.sv
// Small synchronous FIFO with single-cycle flush and occupancy count.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign wr_en   = push & (~full | pop);
  assign rd_en   = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties the buffer at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory,
// buffers {pc, instr} pairs and hands them to decode; handles redirect/halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              fetch_en,
  input  logic                              redirect_valid,
  input  logic [31:0]                       redirect_target,
  fetch_sequencer_if.master                 bus,
  output logic                              misalign_err,
  output logic [1:0]                        fetch_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [31:0]     pc;
  logic            push;
  logic            pop;
  logic            empty;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign wr_entry = '{pc: pc, instr: bus.imem_instr};

  // A redirect hides the stale head so nothing is popped in the flush cycle.
  assign bus.if_valid  = ~empty & ~redirect_valid;
  assign bus.if_pc     = empty ? '0 : head.pc;
  assign bus.if_instr  = empty ? '0 : head.instr;
  assign bus.imem_addr = pc;
  assign fetch_state   = state;

  assign pop  = bus.if_valid & bus.if_ready;
  assign push = (state == ST_RUN) & fetch_en & ~redirect_valid &
                ((fifo_count < DEPTH_C) | pop);

  fetch_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (redirect_valid),
    .push   (push),
    .pop    (pop),
    .wr_data(wr_entry),
    .rd_data(head),
    .empty  (empty),
    .count  (fifo_count)
  );

  // Run/halt control; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fetch_en)  state_nxt = ST_RUN;
      ST_RUN:  if (!fetch_en) state_nxt = ST_HALT;
      ST_HALT: if (fetch_en)  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC update (redirect wins over sequential advance) and misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid & (|redirect_target[1:0]);
      if (redirect_valid) begin
        pc <= {redirect_target[31:2], 2'b00};
      end else if (push) begin
        pc <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        misalign_err;
  logic [1:0]  fetch_state;
  logic [1:0]  fifo_count;

  fetch_sequencer_if bus();

  fetch_sequencer #(
    .RESET_PC  (RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .bus            (bus),
    .misalign_err   (misalign_err),
    .fetch_state    (fetch_state),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // Program image: word i is "addi x(i%32), x0, i"; 0x48 holds a fixed word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    logic [5:0]  w;
    if (a >= 32'h100) return NOP;
    if (a == 32'h48) return 32'h0030_0513;
    w = a[7:2];
    r = 32'h13;
    r[31:20] = {6'd0, w};
    r[11:7]  = w[4:0];
    return r;
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);

  int checks = 0;
  int failures = 0;

  fetch_entry_t m_fifo[$];
  fetch_entry_t sb[$];
  fetch_entry_t dlog[$];
  logic [31:0]  m_pc;
  int           m_state;
  bit           m_mis;

  bit          snap_fresh = 1'b0;
  bit          exp_valid;
  int          exp_count;
  logic [31:0] exp_addr;
  int          exp_state;
  bit          exp_mis;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s %s", name, what);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    sb.delete();
    m_pc    = RPC;
    m_state = 0;
    m_mis   = 1'b0;
  endtask

  // One clock: drive inputs, record pre-edge expectations, advance the model.
  task automatic cycle(input bit fe, input bit rv, input logic [31:0] rt, input bit rdy);
    bit pop;
    bit push;
    @(negedge clk);
    fetch_en        = fe;
    redirect_valid  = rv;
    redirect_target = rt;
    bus.if_ready    = rdy;

    exp_count = m_fifo.size();
    exp_addr  = m_pc;
    exp_state = m_state;
    exp_mis   = m_mis;
    exp_valid = (m_fifo.size() > 0) && !rv;
    exp_pc    = '0;
    exp_instr = '0;
    if (m_fifo.size() > 0) begin
      exp_pc    = m_fifo[0].pc;
      exp_instr = m_fifo[0].instr;
    end

    pop  = exp_valid && rdy;
    push = (m_state == 1) && fe && !rv && ((m_fifo.size() < DEPTH) || pop);
    if (pop) sb.push_back(m_fifo.pop_front());
    if (rv) begin
      m_fifo.delete();
      m_pc = {rt[31:2], 2'b00};
    end else if (push) begin
      m_fifo.push_back('{pc: m_pc, instr: mem_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    m_mis = rv && (rt[1:0] != 2'b00);
    case (m_state)
      0: if (fe)  m_state = 1;
      1: if (!fe) m_state = 2;
      2: if (fe)  m_state = 1;
      default: m_state = 0;
    endcase
    snap_fresh = 1'b1;
    #2;
  endtask

  // Monitor: compare visible outputs and consume scoreboard on each handshake.
  always @(negedge clk) begin
    fetch_entry_t e;
    #1;
    if (snap_fresh) begin
      snap_fresh = 1'b0;
      chk("if_valid",     32'(bus.if_valid),  32'(exp_valid));
      chk("fifo_count",   32'(fifo_count),    32'(exp_count));
      chk("imem_addr",    bus.imem_addr,      exp_addr);
      chk("fetch_state",  32'(fetch_state),   32'(exp_state));
      chk("misalign_err", 32'(misalign_err),  32'(exp_mis));
      chk("if_pc",        bus.if_pc,          exp_pc);
      chk("if_instr",     bus.if_instr,       exp_instr);
      if (bus.if_valid && bus.if_ready) begin
        if (sb.size() == 0) begin
          fail_now("deliver", $sformatf("unexpected pc=0x%08h", bus.if_pc));
        end else begin
          e = sb.pop_front();
          chk("deliver_pc",    bus.if_pc,    e.pc);
          chk("deliver_instr", bus.if_instr, e.instr);
        end
        dlog.push_back('{pc: bus.if_pc, instr: bus.if_instr});
      end
      if (sb.size() != 0) begin
        fail_now("deliver", $sformatf("missing pc=0x%08h", sb[0].pc));
        sb.delete();
      end
    end
  end

  task automatic chk_log(input string name, input int idx, input logic [31:0] pc,
                         input logic [31:0] instr);
    if (idx >= dlog.size()) begin
      fail_now(name, $sformatf("no delivery at index %0d", idx));
    end else begin
      chk({name, "_pc"},    dlog[idx].pc,    pc);
      chk({name, "_instr"}, dlog[idx].instr, instr);
    end
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    bus.if_ready    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] frozen;

    bus.if_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_if_valid",  32'(bus.if_valid),   32'd0);
    chk("rst_if_pc",     bus.if_pc,           32'd0);
    chk("rst_if_instr",  bus.if_instr,        32'd0);
    chk("rst_misalign",  32'(misalign_err),   32'd0);
    chk("rst_state",     32'(fetch_state),    32'd0);
    chk("rst_count",     32'(fifo_count),     32'd0);
    chk("rst_imem_addr", bus.imem_addr,       RPC);
    @(negedge clk);
    rst_n = 1'b1;

    // Startup stream
    base = dlog.size();
    repeat (5) cycle(1, 0, '0, 1);
    chk_log("start0", base,     32'h0, 32'h0000_0013);
    chk_log("start1", base + 1, 32'h4, 32'h0010_0093);
    chk_log("start2", base + 2, 32'h8, 32'h0020_0113);

    // Back-pressure after first accept
    apply_reset();
    base = dlog.size();
    n = 0;
    while (dlog.size() == base && n < 10) begin
      cycle(1, 0, '0, 1);
      n++;
    end
    if (dlog.size() == base) fail_now("first_accept", "timeout");
    repeat (4) cycle(1, 0, '0, 0);
    chk("stall_count", 32'(fifo_count), 32'd2);
    chk("stall_addr",  bus.imem_addr,   32'hC);
    repeat (4) cycle(1, 0, '0, 1);
    chk_log("drain0", base + 1, 32'h4, 32'h0010_0093);
    chk_log("drain1", base + 2, 32'h8, 32'h0020_0113);
    chk_log("drain2", base + 3, 32'hC, mem_word(32'hC));

    // Redirect while full
    repeat (3) cycle(1, 0, '0, 0);
    base = dlog.size();
    cycle(1, 1, 32'h48, 0);
    cycle(1, 0, '0, 1);
    chk("redir_valid_off", 32'(bus.if_valid), 32'd0);
    repeat (2) cycle(1, 0, '0, 1);
    chk_log("redir", base, 32'h48, 32'h0030_0513);

    // Misaligned redirect
    base = dlog.size();
    cycle(1, 1, 32'h4A, 1);
    cycle(1, 0, '0, 1);
    chk("mis_pulse_hi", 32'(misalign_err), 32'd1);
    cycle(1, 0, '0, 1);
    chk("mis_pulse_lo", 32'(misalign_err), 32'd0);
    cycle(1, 0, '0, 1);
    chk_log("mis", base, 32'h48, 32'h0030_0513);

    // Halt, drain, resume at frozen address
    repeat (4) cycle(0, 0, '0, 1);
    chk("halt_state", 32'(fetch_state), 32'd2);
    chk("halt_count", 32'(fifo_count),  32'd0);
    frozen = bus.imem_addr;
    repeat (3) cycle(0, 0, '0, 1);
    chk("halt_frozen", bus.imem_addr, frozen);
    base = dlog.size();
    repeat (4) cycle(1, 0, '0, 1);
    chk_log("resume", base, frozen, mem_word(frozen));

    // PC wrap at top of address space
    base = dlog.size();
    cycle(1, 1, 32'hFFFF_FFFC, 1);
    repeat (4) cycle(1, 0, '0, 1);
    chk_log("wrap0", base,     32'hFFFF_FFFC, NOP);
    chk_log("wrap1", base + 1, 32'h0000_0000, 32'h0000_0013);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, rt,
            $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset between edges
    repeat (4) cycle(1, 0, '0, 0);
    @(posedge clk);
    #3;
    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    redirect_valid  = 1'b0;
    bus.if_ready    = 1'b0;
    #1;
    chk("arst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("arst_count",    32'(fifo_count),   32'd0);
    chk("arst_state",    32'(fetch_state),  32'd0);
    chk("arst_addr",     bus.imem_addr,     RPC);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    base = dlog.size();
    repeat (5) cycle(1, 0, '0, 1);
    chk_log("post_rst", base, 32'h0, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the combinational instruction memory for the core's fetch stage.
- Owns the PC and drives the memory word address.
- Captures {PC, instruction} pairs into a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump) with a flush, and supports halting and resuming fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, entries in the fetch buffer (power of two, ≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  fetch enable from the core control.
- redirect_valid  input  1  redirect request, single-cycle or held.
- redirect_target  input  32  new PC.
- imem_addr  output  32  byte address to instruction memory; always equals the PC register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- if_valid  output  1  FIFO head valid toward decode.
- if_ready  input  1  decode accepts the head.
- if_pc  output  32  PC of the head entry; 0 when empty.
- if_instr  output  32  instruction of the head entry; 0 when empty.
- misalign_err  output  1  one-cycle pulse when a redirect target had bits [1:0] ≠ 0.
- fetch_state  output  2  current FSM state, for debug.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  occupancy.

Behaviour:
- Reset (async, rst_n=0) values:
  - PC=RESET_PC, FIFO empty, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, fetch_state=IDLE.
- FSM states: IDLE=0, RUN=1, HALT=2.
  - IDLE→RUN when fetch_en=1.
  - RUN→HALT when fetch_en=0.
  - HALT→RUN when fetch_en=1.
  - Encoding 3 is illegal and recovers to IDLE.
- pop = if_valid & if_ready.
- push = (state==RUN) & fetch_en & ~redirect_valid & (count<FIFO_DEPTH | pop).
- On push:
  - Enqueue {PC, imem_instr}.
  - PC <= PC+4, wrapping modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- No push → PC holds. This covers full with no pop, HALT, IDLE and redirect.
- Full with simultaneous pop: push and pop both occur, count is unchanged, 1 instr/cycle is sustained.
- Empty with push: the entry becomes visible next cycle. There is no bypass; fetch-to-if_valid latency is 1 cycle.
- Startup: with fetch_en=1 from reset release, state is RUN in cycle 1, first push in cycle 1, and if_valid=1 with if_pc=RESET_PC in cycle 2.
- Redirect (highest priority, accepted in every state):
  - FIFO is flushed at the clock edge.
  - PC <= {redirect_target[31:2], 2'b00}.
  - misalign_err <= |redirect_target[1:0] (registered, one cycle).
  - if_valid is forced to 0 during the redirect cycle, so no pop occurs and nothing is delivered from the stale stream.
  - Redirect in cycle N → fetch of the target in cycle N+1 → if_valid with if_pc=target in cycle N+2, in RUN.
  - A redirect held for several cycles re-applies each cycle; fetch starts after deassertion.
- HALT / IDLE:
  - No new fetches, but the FIFO continues to drain to decode.
  - imem_addr is frozen except on redirect.
- Reset mid-operation: all state clears immediately, independent of clk; a pending handshake is dropped.
- if_pc/if_instr must be stable while if_valid=1 and if_ready=0.

Decomposition:
- Shared package fetch_pkg:
  - FSM state encodings.
  - NOP constant 32'h0000_0013.
  - Default RESET_PC.
  - Instruction width XLEN=32.
- One sub-module, fetch_fifo: synchronous FIFO with flush input, parameterised width/depth, async active-low reset, count output.
- The controller instantiates fetch_fifo with width 64.

Test Plan:
- Reset release, fetch_en=1, if_ready=1, memory model loaded with the standard test program → if_valid rises in cycle 2. Accepted pairs are (0x0, 0x00000013), (0x4, 0x00100093), (0x8, 0x00200113), one per cycle.
- if_ready=0 after the first accept → fifo_count saturates at 2 and imem_addr holds at 0xC. Releasing if_ready → pcs 0x4, 0x8, 0xC are delivered in order, with no drops or duplicates.
- FIFO full, redirect_valid pulse with target 0x48 → if_valid=0 the next cycle. Two cycles after the pulse: if_pc=0x48, if_instr=0x00300513. The old entries are never delivered.
- redirect_target=0x4A → misalign_err high for exactly one cycle, and the next delivered if_pc=0x48.
- fetch_en dropped mid-stream → fetch_state=HALT, FIFO drains, imem_addr frozen. fetch_en reasserted → fetch resumes at the frozen address.
- Redirect to 0xFFFF_FFFC with the memory model returning the NOP constant for out-of-range addresses → delivered pcs are 0xFFFF_FFFC then 0x0. rst_n asserted between clock edges → if_valid, fifo_count and fetch_state clear immediately.
